// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter and fetch sequencing with boot hold, stall, halt and fault
//
// Purpose:
//   Holds the instruction address A and sequences it through BOOT, RUN and HALT.
//   In RUN, each valid cycle advances A to A+4 or to the branch target A+ImmOp.
//   A next PC that is misaligned or at or beyond PC_LIMIT is not taken. Instead the
//   unit halts with a sticky fault flag, and A keeps the faulting instruction's address.
//
// Ports:
//   clk          in   1           rising-edge clock
//   rst_n        in   1           asynchronous active-low reset (release expected synchronous to clk)
//   en           in   1           1 = advance this cycle, 0 = stall
//   PCsrc        in   1           1 = take branch/jump target A+ImmOp
//   ImmOp        in   DATA_WIDTH  sign-extended byte offset
//   halt_req     in   1           request orderly stop
//   A            out  DATA_WIDTH  current PC (registered)
//   pc_plus4     out  DATA_WIDTH  A+4 (combinational)
//   valid        out  1           instruction at A executes this cycle (combinational)
//   halted       out  1           FSM is in HALT
//   fault        out  1           sticky: halt caused by a bad next PC
//   instr_count  out  DATA_WIDTH  number of executed instructions

module pc_fetch_unit #(
   parameter int                  DATA_WIDTH  = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC  = '0,
   parameter logic [DATA_WIDTH-1:0] PC_LIMIT  = DATA_WIDTH'(32'h400),
   parameter int                  BOOT_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  PCsrc,
   input  logic [DATA_WIDTH-1:0] ImmOp,
   input  logic                  halt_req,
   output logic [DATA_WIDTH-1:0] A,
   output logic [DATA_WIDTH-1:0] pc_plus4,
   output logic                  valid,
   output logic                  halted,
   output logic                  fault,
   output logic [DATA_WIDTH-1:0] instr_count
);

   localparam logic [1:0] ST_BOOT = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_HALT = 2'd2;

   // Boot hold ends on the clock edge that completes the BOOT_CYCLES-th cycle.
   localparam logic [DATA_WIDTH-1:0] BOOT_LAST = DATA_WIDTH'(BOOT_CYCLES - 1);

   logic [1:0]            r_state;
   logic [DATA_WIDTH-1:0] r_pc;
   logic [DATA_WIDTH-1:0] r_boot_cnt;
   logic [DATA_WIDTH-1:0] r_count;
   logic                  r_fault;

   logic [DATA_WIDTH-1:0] w_pc_plus4;
   logic [DATA_WIDTH-1:0] w_next_pc;
   logic                  w_valid;
   logic                  w_bad_next;

   // All adds wrap modulo 2^DATA_WIDTH. ImmOp is already a byte offset, so no shift.
   assign w_pc_plus4 = r_pc + DATA_WIDTH'(4);
   assign w_next_pc  = PCsrc ? (r_pc + ImmOp) : w_pc_plus4;

   // A halt request suppresses execution of the current instruction.
   assign w_valid    = (r_state == ST_RUN) && en && !halt_req;
   assign w_bad_next = (w_next_pc[1:0] != 2'b00) || (w_next_pc >= PC_LIMIT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_BOOT;
         r_pc       <= RESET_PC;
         r_boot_cnt <= '0;
         r_count    <= '0;
         r_fault    <= 1'b0;
      end else begin
         case (r_state)
            ST_BOOT: begin
               if (halt_req) begin
                  r_state <= ST_HALT;
               end else if (r_boot_cnt >= BOOT_LAST) begin
                  r_state <= ST_RUN;
               end else begin
                  r_boot_cnt <= r_boot_cnt + DATA_WIDTH'(1);
               end
            end
            ST_RUN: begin
               if (halt_req) begin
                  r_state <= ST_HALT;
               end else if (w_valid) begin
                  // The faulting instruction still executed, so it is counted;
                  // only its successor address is rejected.
                  r_count <= r_count + DATA_WIDTH'(1);
                  if (w_bad_next) begin
                     r_state <= ST_HALT;
                     r_fault <= 1'b1;
                  end else begin
                     r_pc <= w_next_pc;
                  end
               end
            end
            default: begin
               r_state <= ST_HALT;
            end
         endcase
      end
   end

   assign A           = r_pc;
   assign pc_plus4    = w_pc_plus4;
   assign valid       = w_valid;
   assign halted      = (r_state == ST_HALT);
   assign fault       = r_fault;
   assign instr_count = r_count;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        PCsrc;
   logic [31:0] ImmOp;
   logic        halt_req;
   logic [31:0] A;
   logic [31:0] pc_plus4;
   logic        valid;
   logic        halted;
   logic        fault;
   logic [31:0] instr_count;

   int checks;
   int failures;

   pc_fetch_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .PCsrc       (PCsrc),
      .ImmOp       (ImmOp),
      .halt_req    (halt_req),
      .A           (A),
      .pc_plus4    (pc_plus4),
      .valid       (valid),
      .halted      (halted),
      .fault       (fault),
      .instr_count (instr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_state(input string tag, input logic [31:0] a, input logic v,
                              input logic h, input logic f, input logic [31:0] cnt);
      check({tag, ".A"},      A,           a);
      check({tag, ".valid"},  {31'd0, valid},  {31'd0, v});
      check({tag, ".halted"}, {31'd0, halted}, {31'd0, h});
      check({tag, ".fault"},  {31'd0, fault},  {31'd0, f});
      check({tag, ".count"},  instr_count, cnt);
   endtask

   // Reset, release, and wait out the two boot cycles with en held low.
   task automatic do_reset();
      rst_n = 1'b0; en = 1'b0; PCsrc = 1'b0; ImmOp = '0; halt_req = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick(); tick();
   endtask

   initial begin
      checks = 0;
      failures = 0;

      // T1 reset and boot hold
      rst_n = 1'b0; en = 1'b0; PCsrc = 1'b0; ImmOp = '0; halt_req = 1'b0;
      tick(); tick();
      check_state("rst", 32'h0, 1'b0, 1'b0, 1'b0, 32'd0);
      rst_n = 1'b1; en = 1'b1;
      #1 check_state("boot0", 32'h0, 1'b0, 1'b0, 1'b0, 32'd0);
      tick();
      check_state("boot1", 32'h0, 1'b0, 1'b0, 1'b0, 32'd0);
      tick();
      check_state("run0", 32'h0, 1'b1, 1'b0, 1'b0, 32'd0);
      check("plus4_0", pc_plus4, 32'h4);
      tick();
      check_state("run1", 32'h4, 1'b1, 1'b0, 1'b0, 32'd1);
      tick();
      check_state("run2", 32'h8, 1'b1, 1'b0, 1'b0, 32'd2);
      tick();
      check_state("run3", 32'hC, 1'b1, 1'b0, 1'b0, 32'd3);

      // T3 stall with PCsrc asserted
      en = 1'b0; PCsrc = 1'b1; ImmOp = 32'h100;
      for (int i = 0; i < 3; i++) begin
         #1 check_state("stall", 32'hC, 1'b0, 1'b0, 1'b0, 32'd3);
         tick();
      end
      check_state("stall_end", 32'hC, 1'b0, 1'b0, 1'b0, 32'd3);
      en = 1'b1; PCsrc = 1'b0;
      tick();
      check_state("unstall", 32'h10, 1'b1, 1'b0, 1'b0, 32'd4);

      // T2 branches backward and forward
      PCsrc = 1'b1; ImmOp = 32'hFFFF_FFF8;
      tick();
      check_state("br_back", 32'h08, 1'b1, 1'b0, 1'b0, 32'd5);
      ImmOp = 32'h20;
      tick();
      check_state("br_fwd", 32'h28, 1'b1, 1'b0, 1'b0, 32'd6);
      ImmOp = 32'hFFFF_FFEC;
      tick();
      check_state("br_to14", 32'h14, 1'b1, 1'b0, 1'b0, 32'd7);

      // T4 halt request beats PCsrc and en
      halt_req = 1'b1; ImmOp = 32'h40;
      #1 check("halt_valid", {31'd0, valid}, 32'd0);
      tick();
      halt_req = 1'b0;
      check_state("halt", 32'h14, 1'b0, 1'b1, 1'b0, 32'd7);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("halt_hold.A", A, 32'h14);
      end
      check("halt_plus4", pc_plus4, 32'h18);
      check_state("halt_end", 32'h14, 1'b0, 1'b1, 1'b0, 32'd7);

      // T5a misaligned target
      do_reset();
      en = 1'b1; PCsrc = 1'b1; ImmOp = 32'h20;
      tick();
      check_state("to20", 32'h20, 1'b1, 1'b0, 1'b0, 32'd1);
      ImmOp = 32'h2;
      tick();
      check_state("misalign", 32'h20, 1'b0, 1'b1, 1'b1, 32'd2);

      // T6 async reset mid-cycle from faulted HALT
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_state("async_rst", 32'h0, 1'b0, 1'b0, 1'b0, 32'd0);
      tick();

      // T5b out-of-range sequential fetch
      do_reset();
      en = 1'b1; PCsrc = 1'b1; ImmOp = 32'h3FC;
      tick();
      check_state("to3FC", 32'h3FC, 1'b1, 1'b0, 1'b0, 32'd1);
      PCsrc = 1'b0;
      tick();
      check_state("range", 32'h3FC, 1'b0, 1'b1, 1'b1, 32'd2);

      // Halt request during the boot hold
      rst_n = 1'b0; en = 1'b1; PCsrc = 1'b0; halt_req = 1'b0;
      tick();
      rst_n = 1'b1; halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      check_state("boot_halt", 32'h0, 1'b0, 1'b1, 1'b0, 32'd0);
      tick(); tick();
      check_state("boot_halt_hold", 32'h0, 1'b0, 1'b1, 1'b0, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
